// File: rtl/acc_cpu_mc.sv
// Multi-cycle register-file CPU: FETCH -> EXEC (-> MEM) -> FETCH; 2 cycles per ALU/branch op, 3+ for LD/ST.
// Stalls in FETCH without instr_valid and in MEM until mem_ack; HALT holds until RESET.
module acc_cpu_mc #(
    parameter  int DW   = 8,
    parameter  int NREG = 4,
    parameter  int AW   = 8,
    localparam int RW   = $clog2(NREG),
    localparam int SW   = $clog2(DW),
    localparam int IW   = 4 + 2*RW + DW
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [IW-1:0] instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    output logic [AW-1:0] pc,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          zero,
    output logic          halted
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [3:0] OP_LDI = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_LD  = 4'd7;
    localparam logic [3:0] OP_ST  = 4'd8;
    localparam logic [3:0] OP_BZ  = 4'd9;
    localparam logic [3:0] OP_JMP = 4'd10;
    localparam logic [3:0] OP_HLT = 4'd15;

    localparam logic [DW-1:0] D_ONE = DW'(1);
    localparam logic [AW-1:0] A_ONE = AW'(1);

    state_t        state;
    logic [IW-1:0] ir;
    logic [DW-1:0] regs [NREG];

    logic [3:0]    op;
    logic [RW-1:0] rd, rs1, rs2;
    logic [DW-1:0] imm;
    logic [SW-1:0] sh;
    logic [DW-1:0] op_a, op_b, alu_res;

    assign op   = ir[IW-1 -: 4];
    assign rd   = ir[DW+2*RW-1 -: RW];
    assign rs1  = ir[DW+RW-1 -: RW];
    assign imm  = ir[DW-1:0];
    assign rs2  = imm[RW-1:0];
    assign sh   = imm[SW-1:0];
    assign op_a = regs[rs1];
    assign op_b = regs[rs2];

    always_comb begin
        alu_res = imm;
        case (op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a + (~op_b + D_ONE);
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_SRL:  alu_res = op_a >> sh;
            OP_SLL:  alu_res = op_a << sh;
            default: alu_res = imm;
        endcase
    end

    // Memory-side outputs come straight from IR and the register file; neither
    // changes while in MEM, so they stay stable until mem_ack.
    assign instr_ready = (state == S_FETCH);
    assign mem_req     = (state == S_MEM);
    assign halted      = (state == S_HALT);
    assign mem_we      = (op == OP_ST);
    assign mem_addr    = op_a[AW-1:0];
    assign mem_wdata   = regs[rd];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_FETCH;
            ir    <= '0;
            pc    <= '0;
            zero  <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    pc    <= pc + A_ONE;
                    case (op)
                        OP_LDI: regs[rd] <= imm;
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SRL, OP_SLL: begin
                            regs[rd] <= alu_res;
                            zero     <= (alu_res == '0);
                        end
                        OP_LD, OP_ST: begin
                            state <= S_MEM;
                            pc    <= pc;
                        end
                        OP_BZ:  if (zero) pc <= imm[AW-1:0];
                        OP_JMP: pc <= imm[AW-1:0];
                        OP_HLT: begin
                            state <= S_HALT;
                            pc    <= pc;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (op == OP_LD) regs[rd] <= mem_rdata;
                        pc    <= pc + A_ONE;
                        state <= S_FETCH;
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_cpu_mc.sv
// Directed-vector bench for acc_cpu_mc (DW=8, NREG=4, AW=8); registers observed via ST.
module tb_acc_cpu_mc;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] instr = 16'hFFFF;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [7:0]  pc;
    logic        mem_req, mem_we;
    logic [7:0]  mem_addr, mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic        zero, halted;

    int n_vec = 0;
    int n_err = 0;

    acc_cpu_mc dut (
        .CLK(CLK), .RESET(RESET),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .zero(zero), .halted(halted)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one instruction; returns one cycle after acceptance (EXEC).
    task automatic fetch(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [7:0] imm);
        int n = 0;
        while (!instr_ready && n < 50) begin
            tick();
            n++;
        end
        chk("fetch_rdy", {31'b0, instr_ready}, 1);
        instr       = {op, rd, rs1, imm};
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr       = 16'hF000;
        chk("exec_rdy", {31'b0, instr_ready}, 0);
    endtask

    // Non-memory instruction: checks the 2-cycle turnaround.
    task automatic op2(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [7:0] imm);
        fetch(op, rd, rs1, imm);
        tick();
        chk("lat2_rdy", {31'b0, instr_ready}, 1);
    endtask

    // Read a register by storing it with an immediate ack.
    task automatic peek(input string tag, input logic [1:0] r, input logic [7:0] exp);
        fetch(4'd8, r, 2'd0, 8'h00);
        tick();
        chk("peek_req", {31'b0, mem_req}, 1);
        chk(tag, {24'b0, mem_wdata}, {24'b0, exp});
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        RESET = 1'b0;
        chk("rst_rdy", {31'b0, instr_ready}, 1);
        chk("rst_pc", {24'b0, pc}, 0);
        chk("rst_zero", {31'b0, zero}, 0);
        chk("rst_halt", {31'b0, halted}, 0);
        chk("rst_req", {31'b0, mem_req}, 0);

        // LDI / ADD
        op2(4'd0, 2'd1, 2'd0, 8'd5);
        op2(4'd0, 2'd2, 2'd0, 8'd3);
        op2(4'd1, 2'd3, 2'd1, 8'd2);
        chk("add_pc", {24'b0, pc}, 3);
        chk("add_zero", {31'b0, zero}, 0);
        peek("add_r3", 2'd3, 8'd8);
        chk("peek_pc", {24'b0, pc}, 4);

        // SUB sets zero, BZ taken, then not taken
        op2(4'd0, 2'd1, 2'd0, 8'd5);
        op2(4'd2, 2'd0, 2'd1, 8'd1);
        chk("sub_zero", {31'b0, zero}, 1);
        peek("sub_r0", 2'd0, 8'd0);
        chk("st_keeps_zero", {31'b0, zero}, 1);
        op2(4'd9, 2'd0, 2'd0, 8'h40);
        chk("bz_taken_pc", {24'b0, pc}, 8'h40);
        op2(4'd1, 2'd2, 2'd1, 8'd1);
        chk("add10_zero", {31'b0, zero}, 0);
        op2(4'd9, 2'd0, 2'd0, 8'h10);
        chk("bz_nt_pc", {24'b0, pc}, 8'h42);

        // Shifts and wrap-around ADD
        op2(4'd0, 2'd1, 2'd0, 8'h81);
        op2(4'd5, 2'd2, 2'd1, 8'd1);
        peek("srl", 2'd2, 8'h40);
        op2(4'd6, 2'd2, 2'd1, 8'd1);
        peek("sll", 2'd2, 8'h02);
        op2(4'd3, 2'd2, 2'd1, 8'd1);
        peek("and", 2'd2, 8'h81);
        op2(4'd0, 2'd1, 2'd0, 8'hFF);
        op2(4'd0, 2'd2, 2'd0, 8'h01);
        op2(4'd1, 2'd3, 2'd1, 8'd2);
        chk("addwrap_zero", {31'b0, zero}, 1);
        peek("addwrap_r3", 2'd3, 8'h00);
        op2(4'd4, 2'd3, 2'd2, 8'd2);
        chk("or_zero", {31'b0, zero}, 0);
        peek("or_r3", 2'd3, 8'h01);

        // ST with ack after 3 MEM cycles
        op2(4'd0, 2'd1, 2'd0, 8'h10);
        op2(4'd0, 2'd2, 2'd0, 8'hAB);
        fetch(4'd8, 2'd2, 2'd1, 8'h00);
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("st_req", {31'b0, mem_req}, 1);
            chk("st_we", {31'b0, mem_we}, 1);
            chk("st_addr", {24'b0, mem_addr}, 8'h10);
            chk("st_wdata", {24'b0, mem_wdata}, 8'hAB);
            if (c == 2) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        chk("st_done_req", {31'b0, mem_req}, 0);
        chk("st_done_rdy", {31'b0, instr_ready}, 1);

        // LD r1 <- mem[r1]; stray ack during EXEC must be ignored
        mem_ack   = 1'b1;
        mem_rdata = 8'h55;
        fetch(4'd7, 2'd1, 2'd1, 8'h00);
        tick();
        mem_ack = 1'b0;
        chk("ld_req", {31'b0, mem_req}, 1);
        chk("ld_we", {31'b0, mem_we}, 0);
        chk("ld_addr", {24'b0, mem_addr}, 8'h10);
        mem_rdata = 8'hAB;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        peek("ld_r1", 2'd1, 8'hAB);

        // PC wrap and FETCH stall
        op2(4'd10, 2'd0, 2'd0, 8'hFF);
        chk("jmp_pc", {24'b0, pc}, 8'hFF);
        op2(4'd11, 2'd0, 2'd0, 8'h00);
        chk("wrap_pc", {24'b0, pc}, 8'h00);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_rdy", {31'b0, instr_ready}, 1);
            chk("stall_pc", {24'b0, pc}, 8'h00);
        end
        peek("stall_r1", 2'd1, 8'hAB);

        // Reset in the middle of a load
        op2(4'd0, 2'd3, 2'd0, 8'h77);
        fetch(4'd7, 2'd3, 2'd1, 8'h00);
        tick();
        chk("mid_req", {31'b0, mem_req}, 1);
        #3;
        RESET = 1'b1;
        #1;
        chk("arst_req", {31'b0, mem_req}, 0);
        chk("arst_pc", {24'b0, pc}, 0);
        chk("arst_rdy", {31'b0, instr_ready}, 1);
        mem_rdata = 8'hEE;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        RESET   = 1'b0;
        peek("arst_r3", 2'd3, 8'h00);

        // HALT
        fetch(4'd15, 2'd0, 2'd0, 8'h00);
        tick();
        instr       = 16'h0155;
        instr_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("halt_flag", {31'b0, halted}, 1);
            chk("halt_rdy", {31'b0, instr_ready}, 0);
            chk("halt_pc", {24'b0, pc}, 8'h01);
            tick();
        end
        instr_valid = 1'b0;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("unhalt", {31'b0, halted}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
